// File: rtl/sync_fifo_v2_pkg.sv
// Shared sizing helpers and reset constants for sync_fifo_v2.
package sync_fifo_v2_pkg;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address 0..depth-1, never narrower than one bit.
  function automatic int pw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam logic RST_FLAG  = 1'b0;
  localparam int   RST_PTR   = 0;
  localparam int   RST_COUNT = 0;
  localparam int   RST_DATA  = 0;

endpackage

// File: rtl/sync_fifo_v2_if.sv
// Handshake/status bundle between a producer/consumer and sync_fifo_v2.
// Optional sticky error ports exist only when FIFO_STICKY_ERR_EN is defined.
interface sync_fifo_v2_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int CW         = 4
);
  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [CW-1:0]         af_thresh;
  logic [CW-1:0]         ae_thresh;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CW-1:0]         count;
`ifdef FIFO_STICKY_ERR_EN
  logic                  err_clr;
  logic                  overflow_sticky;
  logic                  underflow_sticky;

  modport master (
    output wr_en, data_in, rd_en, af_thresh, ae_thresh, err_clr,
    input  data_out, rd_valid, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count, overflow_sticky, underflow_sticky
  );
  modport slave (
    input  wr_en, data_in, rd_en, af_thresh, ae_thresh, err_clr,
    output data_out, rd_valid, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count, overflow_sticky, underflow_sticky
  );
`else
  modport master (
    output wr_en, data_in, rd_en, af_thresh, ae_thresh,
    input  data_out, rd_valid, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count
  );
  modport slave (
    input  wr_en, data_in, rd_en, af_thresh, ae_thresh,
    output data_out, rd_valid, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count
  );
`endif
endinterface

// File: rtl/sync_fifo_v2_wrap_ptr.sv
// fifo_wrap_ptr: modulo-DEPTH pointer with explicit DEPTH-1 -> 0 wrap,
// so non-power-of-two depths never rely on binary rollover.
module fifo_wrap_ptr
  import sync_fifo_v2_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = pw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  logic [PW-1:0] ptr_q, ptr_d;

  // Advance on inc, wrapping at the last valid slot.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= PW'(RST_PTR);
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: single-clock FIFO, arbitrary depth, programmable almost
// thresholds, occupancy count, standard or first-word-fall-through read.
// A write while full is taken when a read is taken in the same cycle.
// Optional macro FIFO_STICKY_ERR_EN adds err_clr and sticky error outputs.
module sync_fifo_v2
  import sync_fifo_v2_pkg::*;
#(
  parameter  int FIFO_WIDTH = 16,
  parameter  int FIFO_DEPTH = 8,
  parameter  int FWFT       = 0,
  localparam int CW         = cw(FIFO_DEPTH),
  localparam int PW         = pw(FIFO_DEPTH)
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_v2_if.slave  bus
);
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full, empty, rd_acc, wr_acc;

  // Accept decisions and next count/pulse flags from pre-edge state.
  always_comb begin
    full        = (count_q == CW'(FIFO_DEPTH));
    empty       = (count_q == '0);
    rd_acc      = bus.rd_en && !empty;
    wr_acc      = bus.wr_en && (!full || rd_acc);
    count_d     = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    wr_ack_d    = wr_acc;
    overflow_d  = bus.wr_en && !wr_acc;
    underflow_d = bus.rd_en && !rd_acc;
  end

  // Occupancy and one-cycle status pulses; reset overrides any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= CW'(RST_COUNT);
      wr_ack_q    <= RST_FLAG;
      overflow_q  <= RST_FLAG;
      underflow_q <= RST_FLAG;
    end else begin
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr] <= bus.data_in;
  end

  fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
    .clk (clk), .rst (rst), .inc (wr_acc), .ptr (wr_ptr)
  );
  fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
    .clk (clk), .rst (rst), .inc (rd_acc), .ptr (rd_ptr)
  );

  if (FWFT == 0) begin : g_std
    logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rd_valid_q, rd_valid_d;

    // Registered read: capture head on accept, otherwise hold the last word.
    always_comb begin
      data_out_d = data_out_q;
      rd_valid_d = rd_acc;
      if (rd_acc) data_out_d = mem[rd_ptr];
    end

    // Read data register.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_out_q <= FIFO_WIDTH'(RST_DATA);
        rd_valid_q <= RST_FLAG;
      end else begin
        data_out_q <= data_out_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
  end else begin : g_fwft
    // Head word is always presented; rd_en only pops it.
    assign bus.data_out = mem[rd_ptr];
    assign bus.rd_valid = !empty;
  end

`ifdef FIFO_STICKY_ERR_EN
  logic ovf_sticky_q, ovf_sticky_d;
  logic udf_sticky_q, udf_sticky_d;

  // Sticky errors: a new error in the same cycle beats err_clr.
  always_comb begin
    ovf_sticky_d = overflow_d  ? 1'b1 : (bus.err_clr ? 1'b0 : ovf_sticky_q);
    udf_sticky_d = underflow_d ? 1'b1 : (bus.err_clr ? 1'b0 : udf_sticky_q);
  end

  // Sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky_q <= RST_FLAG;
      udf_sticky_q <= RST_FLAG;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end

  assign bus.overflow_sticky  = ovf_sticky_q;
  assign bus.underflow_sticky = udf_sticky_q;
`endif

  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count_q >= bus.af_thresh);
  assign bus.almostempty = (count_q <= bus.ae_thresh);
  assign bus.count       = count_q;
endmodule
